// File: rtl/dpram_pkg.sv
// Shared constants and types for the true dual-port RAM with clear sequencer.
package dpram_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: walks every address once, one word per clock, raising busy meanwhile.
module dpram_clr_seq #(
  parameter int ADDR_WIDTH   = 10,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);
  import dpram_pkg::*;

  clr_state_t            r_state;
  clr_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      CLR_IDLE: begin
        if (clear_req) w_state_nxt = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        // Address wraps back to 0 naturally on the last word.
        w_addr_nxt = r_addr + 1'b1;
        if (r_addr == {ADDR_WIDTH{1'b1}}) w_state_nxt = CLR_IDLE;
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RST != 0) ? CLR_SWEEP : CLR_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign busy     = (r_state == CLR_SWEEP);
  assign clr_we   = busy;
  assign clr_addr = r_addr;

endmodule

// File: rtl/dpram_tdp_clr.sv
// Single-clock true dual-port RAM, byte-enable writes, selectable same-port RDW mode,
// optional output register, and a clear sweep that owns port A while busy.
module dpram_tdp_clr #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int WRITE_MODE   = 0,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear_req,
  output logic                             busy,
  output logic                             collision,
  input  logic [ADDR_WIDTH-1:0]            address_a,
  input  logic [DATA_WIDTH-1:0]            data_a,
  input  logic                             wren_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  output logic [DATA_WIDTH-1:0]            q_a,
  input  logic [ADDR_WIDTH-1:0]            address_b,
  input  logic [DATA_WIDTH-1:0]            data_b,
  input  logic                             wren_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  output logic [DATA_WIDTH-1:0]            q_b
);
  import dpram_pkg::*;

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_busy;

  dpram_clr_seq #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLEAR_ON_RST(CLEAR_ON_RST)
  ) u_clr_seq (
    .clock    (clock),
    .reset    (reset),
    .clear_req(clear_req),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (w_busy)
  );

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_we_a;
  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [DATA_WIDTH-1:0] w_data_a;
  logic [NB-1:0]         w_be_a;
  logic                  w_we_b;

  assign w_we_a   = w_busy ? w_clr_we   : wren_a;
  assign w_addr_a = w_busy ? w_clr_addr : address_a;
  assign w_data_a = w_busy ? '0         : data_a;
  assign w_be_a   = w_busy ? '1         : be_a;
  assign w_we_b   = !w_busy && wren_b;

  // Port A lanes are written after port B so A wins overlapping lanes.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (w_we_b && be_b[i])
        r_mem[address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_we_a && w_be_a[i])
        r_mem[w_addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b, w_wf_a, w_wf_b, w_q1_a, w_q1_b;

  // Cross-port reads always see the stored word; only the own port's lanes merge in.
  always_comb begin
    w_rd_a = r_mem[address_a];
    w_rd_b = r_mem[address_b];
    w_wf_a = w_rd_a;
    w_wf_b = w_rd_b;
    for (int i = 0; i < NB; i++) begin
      if (wren_a && be_a[i]) w_wf_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wren_b && be_b[i]) w_wf_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    w_q1_a = (WRITE_MODE == WM_WRITE_FIRST) ? w_wf_a : w_rd_a;
    w_q1_b = (WRITE_MODE == WM_WRITE_FIRST) ? w_wf_b : w_rd_b;
  end

  logic [DATA_WIDTH-1:0] r_q1_a, r_q1_b;
  logic                  r_collision;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q1_a      <= '0;
      r_q1_b      <= '0;
      r_collision <= 1'b0;
    end else begin
      r_q1_a      <= w_busy ? '0 : w_q1_a;
      r_q1_b      <= w_busy ? '0 : w_q1_b;
      r_collision <= !w_busy && wren_a && wren_b && (address_a == address_b) && ((be_a & be_b) != '0);
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_q2_a, r_q2_b;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_q2_a <= '0;
        r_q2_b <= '0;
      end else begin
        r_q2_a <= r_q1_a;
        r_q2_b <= r_q1_b;
      end
    end
    assign q_a = r_q2_a;
    assign q_b = r_q2_b;
  end else begin : g_lat1
    assign q_a = r_q1_a;
    assign q_b = r_q1_b;
  end

  assign busy      = w_busy;
  assign collision = r_collision;

endmodule

// File: tb/tb_dpram_tdp_clr.sv
// Directed bench: u_dut is write-first/latency 1, u_dut2 read-first/latency 2, same stimulus.
module tb_dpram_tdp_clr;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_req;
  logic [3:0]  address_a, address_b;
  logic [15:0] data_a, data_b;
  logic        wren_a, wren_b;
  logic [1:0]  be_a, be_b;
  logic        busy, collision, busy2, collision2;
  logic [15:0] q_a, q_b, q_a2, q_b2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dpram_tdp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .WRITE_MODE(0),
                  .READ_LATENCY(1), .CLEAR_ON_RST(1)) u_dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy), .collision(collision),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .be_a(be_a), .q_a(q_a),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .be_b(be_b), .q_b(q_b));

  dpram_tdp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .WRITE_MODE(1),
                  .READ_LATENCY(2), .CLEAR_ON_RST(1)) u_dut2 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy2), .collision(collision2),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .be_a(be_a), .q_a(q_a2),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .be_b(be_b), .q_b(q_b2));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; clear_req = 1'b0;
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    wren_a = 1'b0; wren_b = 1'b0; be_a = '0; be_b = '0;
    tick; tick;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %0b want 1", busy); end
    n_checks++; if (q_a !== 16'h0 || q_b !== 16'h0) begin n_fail++; $display("FAIL rst_q got %h/%h want 0000/0000", q_a, q_b); end
    n_checks++; if (q_a2 !== 16'h0 || collision !== 1'b0) begin n_fail++; $display("FAIL rst_q2_col got %h/%0b want 0000/0", q_a2, collision); end
    reset = 1'b0;
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL rst_sweep_len got %0d want 16", n); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy2 got %0b want 0", busy2); end
    for (int i = 0; i < 16; i++) begin
      address_a = 4'(i); address_b = 4'(15 - i);
      tick;
      n_checks++;
      if (q_a !== 16'h0 || q_b !== 16'h0) begin
        n_fail++; $display("FAIL rst_read_zero addr %0d got %h/%h want 0000/0000", i, q_a, q_b);
      end
    end
  endtask

  task automatic test_write_read;
    address_a = 4'd3; data_a = 16'hBEEF; be_a = 2'b11; wren_a = 1'b1;
    tick;
    wren_a = 1'b0; address_b = 4'd3;
    tick;
    n_checks++; if (q_b !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_lat1 got %h want beef", q_b); end
    tick;
    n_checks++; if (q_b2 !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_lat2 got %h want beef", q_b2); end
  endtask

  task automatic test_byte_enable;
    address_a = 4'd5; data_a = 16'h1234; be_a = 2'b11; wren_a = 1'b1;
    tick;
    data_a = 16'hAB00; be_a = 2'b10;
    tick;
    n_checks++; if (q_a !== 16'hAB34) begin n_fail++; $display("FAIL be_write_first got %h want ab34", q_a); end
    wren_a = 1'b0;
    tick;
    n_checks++; if (q_a2 !== 16'h1234) begin n_fail++; $display("FAIL be_read_first got %h want 1234", q_a2); end
    n_checks++; if (q_a !== 16'hAB34) begin n_fail++; $display("FAIL be_stored got %h want ab34", q_a); end
    tick;
    n_checks++; if (q_a2 !== 16'hAB34) begin n_fail++; $display("FAIL be_stored_lat2 got %h want ab34", q_a2); end
  endtask

  task automatic test_collision;
    address_a = 4'd7; address_b = 4'd7;
    data_a = 16'h1111; data_b = 16'h2222; be_a = 2'b11; be_b = 2'b11;
    wren_a = 1'b1; wren_b = 1'b1;
    tick;
    n_checks++; if (collision !== 1'b1 || collision2 !== 1'b1) begin n_fail++; $display("FAIL col_pulse got %0b/%0b want 1/1", collision, collision2); end
    wren_a = 1'b0; wren_b = 1'b0;
    tick;
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL col_one_cycle got %0b want 0", collision); end
    n_checks++; if (q_a !== 16'h1111) begin n_fail++; $display("FAIL col_a_wins got %h want 1111", q_a); end
    be_a = 2'b01; be_b = 2'b10; wren_a = 1'b1; wren_b = 1'b1;
    tick;
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL col_disjoint got %0b want 0", collision); end
    wren_a = 1'b0; wren_b = 1'b0;
    tick;
    n_checks++; if (q_a !== 16'h2211) begin n_fail++; $display("FAIL col_lane_merge got %h want 2211", q_a); end
  endtask

  task automatic test_cross_rdw;
    address_a = 4'd9; data_a = 16'h0000; be_a = 2'b11; wren_a = 1'b1;
    tick;
    data_a = 16'h5555; address_b = 4'd9;
    tick;
    n_checks++; if (q_b !== 16'h0000) begin n_fail++; $display("FAIL xrdw_old got %h want 0000", q_b); end
    wren_a = 1'b0;
    tick;
    n_checks++; if (q_b !== 16'h5555) begin n_fail++; $display("FAIL xrdw_new got %h want 5555", q_b); end
    n_checks++; if (q_b2 !== 16'h0000) begin n_fail++; $display("FAIL xrdw_old_lat2 got %h want 0000", q_b2); end
    tick;
    n_checks++; if (q_b2 !== 16'h5555) begin n_fail++; $display("FAIL xrdw_new_lat2 got %h want 5555", q_b2); end
  endtask

  task automatic test_clear_abort;
    int n;
    wren_a = 1'b1; be_a = 2'b11; data_a = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin address_a = 4'(i); tick; end
    wren_a = 1'b0; address_a = 4'd15;
    tick;
    n_checks++; if (q_a !== 16'hFFFF) begin n_fail++; $display("FAIL clr_fill got %h want ffff", q_a); end
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_start got %0b want 1", busy); end
    address_b = 4'd15;
    for (int i = 0; i < 5; i++) tick;
    n_checks++; if (q_b !== 16'h0000) begin n_fail++; $display("FAIL clr_q_held got %h want 0000", q_b); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1 || q_b !== 16'h0) begin n_fail++; $display("FAIL clr_rst_mid got %0b/%h want 1/0000", busy, q_b); end
    tick;
    reset = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 5) begin
        wren_a = 1'b1; address_a = 4'd1; data_a = 16'hFFFF; be_a = 2'b11;
        wren_b = 1'b1; address_b = 4'd2; data_b = 16'hFFFF; be_b = 2'b11;
      end
      tick;
      n++;
    end
    wren_a = 1'b0; wren_b = 1'b0;
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL clr_restart_len got %0d want 16", n); end
    for (int i = 0; i < 16; i++) begin
      address_a = 4'(i); address_b = 4'(15 - i);
      tick;
      n_checks++;
      if (q_a !== 16'h0 || q_b !== 16'h0 || q_a2 !== 16'h0) begin
        n_fail++; $display("FAIL clr_read_zero addr %0d got %h/%h/%h want 0000", i, q_a, q_b, q_a2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_enable;
    test_collision;
    test_cross_rdw;
    test_clear_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
